// File: rtl/stage_m.sv
// ---------------------------------------------------------------------------
// stage_m : memory stage of the combined ARM/RISC-V pipeline.
//
// Holds the E->M pipeline register and runs a req/ack data-bus master for
// loads and stores. Stores get byte-lane steering and replicated write data.
// Loads get their returned byte/half selected and zero/sign extended.
// The stage raises StallM while a bus access is outstanding. It reports
// misaligned accesses and bus timeouts on FaultM as a one-cycle pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   *E inputs         instruction fields from execute
//   FlushM            load a bubble into M at the next edge
//   ALUResultM, RdM, PCPlus4M, ResultSrcM, armM   registered fields
//   RegWriteM         registered write enable, forced 0 on any fault
//   ReadDataM         extended load data (combinational from DRData)
//   StallM            freeze F/D/E/M while the bus access is pending
//   FaultM            01 misaligned, 10 bus timeout
//   DAddr/DWData/DByteEn/DWe/DReq, DAck/DRData   data-bus master
// ---------------------------------------------------------------------------
module stage_m #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RdE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ResultSrcE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  MemSizeE,
    input  logic        MemSignedE,
    input  logic        armE,
    input  logic        FlushM,
    output logic [31:0] ALUResultM,
    output logic [31:0] ReadDataM,
    output logic [4:0]  RdM,
    output logic [31:0] PCPlus4M,
    output logic [1:0]  ResultSrcM,
    output logic        RegWriteM,
    output logic        armM,
    output logic        StallM,
    output logic [1:0]  FaultM,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DByteEn,
    output logic        DWe,
    output logic        DReq,
    input  logic        DAck,
    input  logic [31:0] DRData
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [1:0]  rsrc;
        logic        regw;
        logic        memw;
        logic [1:0]  size;
        logic        sgn;
        logic        arm;
    } mreg_t;

    mreg_t   m_q, m_d;
    state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic    done_q, done_d;

    logic [31:0] a;
    logic        is_mem, is_half, is_word, misaligned, memop, timeout;
    logic [3:0]  lane_be;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // ---------------- address decode / request ----------------
    always_comb begin
        a          = m_q.alu;
        is_mem     = m_q.rsrc[0] | m_q.memw;
        is_half    = (m_q.size == 2'b01);
        is_word    = m_q.size[1];
        misaligned = (is_half & a[0]) | (is_word & (a[1:0] != 2'b00));
        memop      = is_mem & ~misaligned;
        timeout    = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
        // done keeps a completed access from being re-requested if the
        // register is ever held past its DAck.
        DReq       = memop & ~done_q & ~timeout;
        StallM     = DReq & ~DAck;
    end

    // ---------------- M pipeline register ----------------
    always_comb begin
        m_d = m_q;
        if (FlushM) begin
            m_d = '0;
        end else if (!StallM) begin
            m_d.alu  = ALUResultE;
            m_d.wd   = WriteDataE;
            m_d.rd   = RdE;
            m_d.pc4  = PCPlus4E;
            m_d.rsrc = ResultSrcE;
            m_d.regw = RegWriteE;
            m_d.memw = MemWriteE;
            m_d.size = MemSizeE;
            m_d.sgn  = MemSignedE;
            m_d.arm  = armE;
        end
    end

    // ---------------- bus FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        if (StallM && !FlushM) begin
            done_d = done_q | (DReq & DAck);
        end
        if (FlushM) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // The IDLE request cycle counts as the first outstanding
                    // cycle, so WAIT starts with cnt=1.
                    if (DReq && !DAck) begin
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
                WAIT: begin
                    if (DAck || timeout || !DReq) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q     <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            m_q     <= m_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // ---------------- store lanes ----------------
    always_comb begin
        case (m_q.size)
            2'b00: begin
                lane_be = 4'b0001 << a[1:0];
                DWData  = {4{m_q.wd[7:0]}};
            end
            2'b01: begin
                lane_be = a[1] ? 4'b1100 : 4'b0011;
                DWData  = {2{m_q.wd[15:0]}};
            end
            default: begin
                lane_be = 4'b1111;
                DWData  = m_q.wd;
            end
        endcase
        // Non-memory instructions and bubbles show no active lanes.
        DByteEn = is_mem ? lane_be : 4'b0000;
        DAddr   = {a[31:2], 2'b00};
        DWe     = m_q.memw;
    end

    // ---------------- load extension ----------------
    always_comb begin
        case (a[1:0])
            2'b00:   rbyte = DRData[7:0];
            2'b01:   rbyte = DRData[15:8];
            2'b10:   rbyte = DRData[23:16];
            default: rbyte = DRData[31:24];
        endcase
        rhalf = a[1] ? DRData[31:16] : DRData[15:0];
        case (m_q.size)
            2'b00:   ReadDataM = {{24{m_q.sgn & rbyte[7]}}, rbyte};
            2'b01:   ReadDataM = {{16{m_q.sgn & rhalf[15]}}, rhalf};
            default: ReadDataM = DRData;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        if (timeout)                  FaultM = 2'b10;
        else if (is_mem & misaligned) FaultM = 2'b01;
        else                          FaultM = 2'b00;
        ALUResultM = m_q.alu;
        RdM        = m_q.rd;
        PCPlus4M   = m_q.pc4;
        ResultSrcM = m_q.rsrc;
        armM       = m_q.arm;
        RegWriteM  = m_q.regw & (FaultM == 2'b00);
    end

endmodule

// File: tb/tb_stage_m.sv
module tb_stage_m;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ResultSrcE, MemSizeE;
    logic        RegWriteE, MemWriteE, MemSignedE, armE, FlushM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, DAddr, DWData, DRData;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM, FaultM;
    logic        RegWriteM, armM, StallM, DWe, DReq, DAck;
    logic [3:0]  DByteEn;

    stage_m #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .armE(armE), .FlushM(FlushM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .armM(armM), .StallM(StallM),
        .FaultM(FaultM), .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn), .DWe(DWe),
        .DReq(DReq), .DAck(DAck), .DRData(DRData)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int off;
        off = int'(a % 4);
        if (sz == 2'd0) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (sz == 2'd1) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return rd;
    endfunction

    task automatic nop_e();
        ALUResultE = '0; WriteDataE = '0; RdE = '0; PCPlus4E = '0;
        ResultSrcE = '0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        MemSizeE = '0; MemSignedE = 1'b0; armE = 1'b0;
    endtask

    // Issues one instruction into M and follows it until it leaves.
    // nwait < 0 means the bus never acknowledges.
    task automatic run_op(input logic [1:0] rsrc, input logic memw, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic regw, input logic arm,
                          input logic [31:0] pc4, input int nwait, input logic [31:0] rdat);
        bit is_mem, mis, fin;
        int stalls;
        is_mem = rsrc[0] | memw;
        mis    = is_mem && m_mis(sz, a);
        fin    = 1'b0;
        stalls = 0;
        @(negedge clk);
        ALUResultE = a; WriteDataE = wd; RdE = rd; PCPlus4E = pc4; ResultSrcE = rsrc;
        RegWriteE = regw; MemWriteE = memw; MemSizeE = sz; MemSignedE = sgn; armE = arm;
        @(posedge clk); #1;
        nop_e();
        chk("alu_m", ALUResultM, a);
        chk("rd_m", 32'(RdM), 32'(rd));
        chk("pc4_m", PCPlus4M, pc4);
        chk("rsrc_m", 32'(ResultSrcM), 32'(rsrc));
        chk("arm_m", 32'(armM), 32'(arm));
        if (!is_mem || mis) begin
            chk("dreq_nomem", 32'(DReq), 0);
            chk("stall_nomem", 32'(StallM), 0);
            chk("fault_nomem", 32'(FaultM), mis ? 32'd1 : 32'd0);
            chk("regw_nomem", 32'(RegWriteM), mis ? 32'd0 : 32'(regw));
            @(posedge clk); #1;
            chk("fault_pulse", 32'(FaultM), 0);
            return;
        end
        for (int c = 0; c < 64 && !fin; c++) begin
            DAck   = (c == nwait);
            DRData = DAck ? rdat : $urandom;
            #1;
            if (nwait < 0 && c == TO - 1) begin
                chk("to_dreq", 32'(DReq), 0);
                chk("to_stall", 32'(StallM), 0);
                chk("to_fault", 32'(FaultM), 2);
                chk("to_regw", 32'(RegWriteM), 0);
                fin = 1'b1;
            end else begin
                chk("dreq", 32'(DReq), 1);
                chk("daddr", DAddr, a & 32'hFFFF_FFFC);
                chk("dbe", 32'(DByteEn), 32'(m_be(sz, a)));
                chk("dwe", 32'(DWe), 32'(memw));
                if (memw) chk("dwdata", DWData, m_wd(sz, wd));
                chk("stall", 32'(StallM), 32'(!DAck));
                if (DAck) begin
                    if (!memw) chk("rdata", ReadDataM, m_rd(sz, sgn, a, rdat));
                    chk("regw_ack", 32'(RegWriteM), 32'(regw));
                    chk("fault_ack", 32'(FaultM), 0);
                    fin = 1'b1;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk); #1;
            DAck = 1'b0;
        end
        DAck = 1'b0;
        chk("completed", 32'(fin), 1);
        chk("nstall", stalls, (nwait < 0) ? TO - 1 : nwait);
    endtask

    // Starts a load that never gets acked, then aborts it in WAIT cycle 2.
    task automatic abort_op(input bit use_rst);
        @(negedge clk);
        ALUResultE = 32'h200; ResultSrcE = 2'b01; MemSizeE = 2'b10; RegWriteE = 1'b1; RdE = 5'd7;
        @(posedge clk); #1;
        nop_e();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_abort_stall", 32'(StallM), 1);
        @(negedge clk);
        if (use_rst) rst = 1'b1; else FlushM = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; FlushM = 1'b0;
        chk("abort_dreq", 32'(DReq), 0);
        chk("abort_stall", 32'(StallM), 0);
        chk("abort_fault", 32'(FaultM), 0);
        chk("abort_alu", ALUResultM, 0);
        chk("abort_be", 32'(DByteEn), 0);
        chk("abort_regw", 32'(RegWriteM), 0);
    endtask

    logic [1:0]  r_sz, r_rsrc;
    logic [31:0] r_a, r_wd, r_rdat;
    logic        r_memw, r_sgn;
    int          r_kind, r_nw;

    initial begin
        rst = 1'b1; FlushM = 1'b0; DAck = 1'b0; DRData = '0;
        nop_e();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dreq", 32'(DReq), 0);
        chk("rst_stall", 32'(StallM), 0);
        chk("rst_fault", 32'(FaultM), 0);
        chk("rst_regw", 32'(RegWriteM), 0);
        chk("rst_alu", ALUResultM, 0);
        chk("rst_be", 32'(DByteEn), 0);
        chk("rst_wd", DWData, 0);
        chk("rst_rdata", ReadDataM, 0);
        @(negedge clk);
        rst = 1'b0;

        // lw, three stall cycles
        run_op(2'b01, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 1'b0, 32'h44, 3, 32'hDEADBEEF);
        // lb signed, zero wait
        run_op(2'b01, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 32'h48, 0, 32'h80FF0000);
        // sh
        run_op(2'b00, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 32'h4C, 1, 32'h0);
        // misaligned lw
        run_op(2'b01, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd5, 1'b1, 1'b0, 32'h50, 0, 32'h0);
        // timeout
        run_op(2'b01, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd6, 1'b1, 1'b0, 32'h54, -1, 32'h0);
        // non-memory op with odd result
        run_op(2'b10, 1'b0, 2'b10, 1'b0, 32'h33, 32'h0, 5'd8, 1'b1, 1'b1, 32'h58, 0, 32'h0);

        abort_op(1'b1);
        run_op(2'b01, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 5'd9, 1'b1, 1'b0, 32'h5C, -1, 32'h0);
        abort_op(1'b0);
        run_op(2'b01, 1'b0, 2'b01, 1'b1, 32'h10E, 32'h0, 5'd10, 1'b1, 1'b0, 32'h60, 2, 32'h8001_7FFF);

        for (int i = 0; i < 80; i++) begin
            r_kind = $urandom_range(0, 2);
            r_nw   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            r_a    = $urandom;
            r_wd   = $urandom;
            r_rdat = $urandom;
            r_sz   = 2'($urandom_range(0, 3));
            r_sgn  = 1'($urandom);
            if (r_kind == 0) begin
                r_rsrc = 2'b01; r_memw = 1'b0;
            end else if (r_kind == 1) begin
                r_rsrc = 2'b00; r_memw = 1'b1;
            end else begin
                r_rsrc = {1'($urandom), 1'b0}; r_memw = 1'b0;
            end
            run_op(r_rsrc, r_memw, r_sz, r_sgn, r_a, r_wd, 5'($urandom), (r_kind != 1) ? 1'($urandom) : 1'b0,
                   1'($urandom), $urandom, r_nw, r_rdat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
